// File: rtl/ws2812b_grb_serializer.sv
// ws2812b_grb_serializer
// Fetches 24-bit GRB pixel words from a synchronous pixel store while
// shipGRB is high. Each word goes out MSB-first on the WS2812B line with
// fixed T_BIT-clock bit periods. Done is raised when the last bit is out,
// and the line is then held low for the T_RESET-clock latch code.
// allDone pulses for one clock when the latch code completes.
//
// Optional build macro GRB_DIM_EN: when it is defined, every captured byte
// is shifted right by 2 (quarter brightness). Timing is not affected.
module ws2812b_grb_serializer #(
  parameter int NUM_LEDS = 8,
  parameter int ADDR_W   = 8,
  parameter int T_BIT    = 125,
  parameter int T0H      = 40,
  parameter int T1H      = 80,
  parameter int T_RESET  = 30000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shipGRB,
  input  logic [23:0]       grb_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              dout,
  output logic              Done,
  output logic              allDone
);

  localparam int BC_W     = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int RC_W     = (T_RESET > 1) ? $clog2(T_RESET) : 1;
  localparam int TOT_BITS = 24 * NUM_LEDS;
  localparam int TOT_W    = $clog2(TOT_BITS);

  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(T_BIT - 1);
  localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
  localparam logic [BC_W-1:0]  T0H_C     = BC_W'(T0H);
  localparam logic [BC_W-1:0]  T1H_C     = BC_W'(T1H);
  localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(T_RESET - 1);
  localparam logic [TOT_W-1:0] TOT_LAST  = TOT_W'(TOT_BITS - 1);
  // First frame-bit index of the final pixel; from there on nothing is prefetched.
  localparam logic [TOT_W-1:0] LAST_PIX0 = TOT_W'(24 * (NUM_LEDS - 1));

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    LATCHRST
  } state_t;

  state_t             state_q,    state_d;
  logic [BC_W-1:0]    bc_q,       bc_d;
  logic [4:0]         bit_q,      bit_d;
  logic [TOT_W-1:0]   tot_q,      tot_d;
  logic [RC_W-1:0]    rc_q,       rc_d;
  logic [23:0]        shift_q,    shift_d;
  logic [23:0]        hold_q,     hold_d;
  logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
  logic               dout_q,     dout_d;
  logic               done_q,     done_d;
  logic               all_done_q, all_done_d;

  // Apply optional quarter-brightness dimming to a captured pixel word.
  function automatic logic [23:0] capture_word(input logic [23:0] w);
`ifdef GRB_DIM_EN
    return {2'b00, w[23:18], 2'b00, w[15:10], 2'b00, w[7:2]};
`else
    return w;
`endif
  endfunction

  // Next-state, counters, prefetch and registered-output computation.
  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    bit_d      = bit_q;
    tot_d      = tot_q;
    rc_d       = rc_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    pix_addr_d = pix_addr_q;

    case (state_q)
      IDLE: begin
        bc_d       = '0;
        bit_d      = '0;
        tot_d      = '0;
        rc_d       = '0;
        pix_addr_d = '0;
        if (shipGRB) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        pix_addr_d = '0;
        state_d    = LATCH;
      end

      LATCH: begin
        shift_d    = capture_word(grb_data);
        pix_addr_d = ADDR_W'(1);
        bc_d       = '0;
        bit_d      = '0;
        tot_d      = '0;
        state_d    = SEND;
      end

      SEND: begin
        // The store answers one clock after pix_addr moved at the start of
        // bit 0, so the next pixel word is taken at bc=1 of that bit.
        if ((bit_q == 5'd0) && (bc_q == BC_ONE) && (tot_q < LAST_PIX0)) begin
          hold_d = capture_word(grb_data);
        end

        if (bc_q == BC_LAST) begin
          bc_d    = '0;
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (tot_q == TOT_LAST) begin
              tot_d   = '0;
              rc_d    = '0;
              state_d = LATCHRST;
            end else begin
              tot_d      = tot_q + 1'b1;
              shift_d    = hold_q;
              pix_addr_d = pix_addr_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tot_d = tot_q + 1'b1;
          end
        end else begin
          bc_d = bc_q + 1'b1;
        end
      end

      LATCHRST: begin
        if (rc_q == RC_LAST) begin
          rc_d       = '0;
          pix_addr_d = '0;
          state_d    = IDLE;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered. They are derived from the next-cycle state and
    // counters, so the registers show the values for the cycle being entered.
    dout_d     = (state_d == SEND) &&
                 (bc_d < (shift_d[23] ? T1H_C : T0H_C));
    done_d     = (state_d == LATCHRST);
    all_done_d = (state_d == LATCHRST) && (rc_d == RC_LAST);
  end

  // State, counter, data and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bc_q       <= '0;
      bit_q      <= '0;
      tot_q      <= '0;
      rc_q       <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      pix_addr_q <= '0;
      dout_q     <= 1'b0;
      done_q     <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      bit_q      <= bit_d;
      tot_q      <= tot_d;
      rc_q       <= rc_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      pix_addr_q <= pix_addr_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      all_done_q <= all_done_d;
    end
  end

  assign pix_addr = pix_addr_q;
  assign dout     = dout_q;
  assign Done     = done_q;
  assign allDone  = all_done_q;

endmodule

// File: tb/tb_ws2812b_grb_serializer.sv
// Testbench for ws2812b_grb_serializer.
// Two instances are used. The 8-pixel instance keeps the default timing,
// and a 1-pixel instance uses a short latch code. Each instance is driven by
// its own thread.
module tb_ws2812b_grb_serializer;

  logic        clk;
  logic        rst8, rst1;
  logic        ship8, ship1;
  logic [23:0] grb8, grb1;
  logic [7:0]  pix8;
  logic [0:0]  pix1;
  logic        dout8, dout1;
  logic        Done8, Done1;
  logic        allDone8, allDone1;
  logic [23:0] word1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] rx_word    [2][8];
  int          rx_hi      [2][192];
  int          rx_bad_per [2];
  int          rx_bad_hi  [2];
  int          rx_total   [2];
  int          rx_bad_addr[2];
  int          rx_to      [2];

  ws2812b_grb_serializer #(
    .NUM_LEDS(8), .ADDR_W(8), .T_BIT(125), .T0H(40), .T1H(80), .T_RESET(30000)
  ) u_dut8 (
    .clk(clk), .reset(rst8), .shipGRB(ship8), .grb_data(grb8),
    .pix_addr(pix8), .dout(dout8), .Done(Done8), .allDone(allDone8)
  );

  ws2812b_grb_serializer #(
    .NUM_LEDS(1), .ADDR_W(1), .T_BIT(125), .T0H(40), .T1H(80), .T_RESET(100)
  ) u_dut1 (
    .clk(clk), .reset(rst1), .shipGRB(ship1), .grb_data(grb1),
    .pix_addr(pix1), .dout(dout1), .Done(Done1), .allDone(allDone1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous pixel stores: word i = 24'h010101*i, and a single-word store.
  always_ff @(posedge clk) grb8 <= 24'h010101 * 24'(pix8);
  always_ff @(posedge clk) grb1 <= (pix1 == 1'b0) ? word1 : 24'h5A5A5A;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] dimmed(input logic [23:0] w);
`ifdef GRB_DIM_EN
    return {2'b00, w[23:18], 2'b00, w[15:10], 2'b00, w[7:2]};
`else
    return w;
`endif
  endfunction

  function automatic logic dout_of(input int sel);
    return (sel != 0) ? dout1 : dout8;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel != 0) ? Done1 : Done8;
  endfunction

  // Decode nbits from the line, sampled on negedges. Returns on the negedge
  // where Done is first seen after the last bit.
  task automatic recv(input int sel, input int nbits);
    int cnt, hi, guard;
    logic b;
    rx_bad_per[sel] = 0; rx_bad_hi[sel] = 0; rx_total[sel] = 0;
    rx_bad_addr[sel] = 0; rx_to[sel] = 0;
    for (int w = 0; w < 8; w++) rx_word[sel][w] = '0;
    guard = 0;
    while (!dout_of(sel) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      rx_to[sel] = 1;
      return;
    end
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0 && pix8 != 8'(i / 24 + 1)) rx_bad_addr[sel]++;
      hi = 0;
      cnt = 0;
      while (dout_of(sel) && cnt < 400) begin
        hi++; cnt++;
        @(negedge clk);
      end
      while (!dout_of(sel) && !done_of(sel) && cnt < 400) begin
        cnt++;
        @(negedge clk);
      end
      rx_total[sel] += cnt;
      rx_hi[sel][i] = hi;
      if (cnt != 125) rx_bad_per[sel]++;
      if (hi == 80) b = 1'b1;
      else if (hi == 40) b = 1'b0;
      else begin
        b = 1'b0;
        rx_bad_hi[sel]++;
      end
      rx_word[sel][i / 24] = {rx_word[sel][i / 24][22:0], b};
    end
  endtask

  initial begin
    #(98000 * 10);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    rst8 = 1'b1; rst1 = 1'b1; ship8 = 1'b1; ship1 = 1'b0; word1 = 24'hA500FF;
    @(posedge clk);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (dout8 || Done8 || allDone8 || pix8 != 8'd0) bad++;
      if (dout1 || Done1 || allDone1 || pix1 != 1'b0) bad++;
    end
    check_eq("reset_outputs", bad, 0);
    rst8 = 1'b0;
    rst1 = 1'b0;
    // First edge after release samples shipGRB in IDLE; dout rises two edges later.
    @(negedge clk);
    @(negedge clk);
    check_eq("fetch_addr", pix8, 0);
    check_eq("rise_lat_before", dout8, 0);
    @(negedge clk);
    check_eq("rise_lat_at", dout8, 1);

    fork
      begin : thread_dut8
        int ad_k, ad_n, dhi, dfall, guard, bad8;
        recv(0, 192);
        ship8 = 1'b0;
        check_eq("f1_timeout", rx_to[0], 0);
        check_eq("f1_periods", rx_bad_per[0], 0);
        check_eq("f1_high_widths", rx_bad_hi[0], 0);
        check_eq("f1_frame_len", rx_total[0], 24000);
        check_eq("f1_pix_addr", rx_bad_addr[0], 0);
        check_eq("f1_addr_end", pix8, 8);
        for (int w = 0; w < 8; w++)
          check_eq($sformatf("f1_word%0d", w), rx_word[0][w], dimmed(24'h010101 * 24'(w)));

        // Latch code: k=0 is the first negedge with Done high.
        ad_k = -1; ad_n = 0; dhi = 0; dfall = -1;
        for (int k = 0; k <= 30000; k++) begin
          if (allDone8) begin
            ad_n++;
            if (ad_k < 0) ad_k = k;
          end
          if (k < 30000 && dout8) dhi++;
          if (!Done8 && dfall < 0) dfall = k;
          if (k < 30000) @(negedge clk);
        end
        check_eq("latch_alldone_at", ad_k, 29999);
        check_eq("latch_alldone_width", ad_n, 1);
        check_eq("latch_dout_low", dhi, 0);
        check_eq("latch_done_fall", dfall, 30000);
        check_eq("latch_addr_clear", pix8, 0);

        // Reset in pixel 3, bit 10.
        ship8 = 1'b1;
        guard = 0;
        while (!dout8 && guard < 10) begin
          @(negedge clk);
          guard++;
        end
        check_eq("mid_start", dout8, 1);
        repeat (82 * 125 + 10) @(negedge clk);
        rst8 = 1'b1;
        ship8 = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_dout", dout8, 0);
        check_eq("mid_rst_addr", pix8, 0);
        check_eq("mid_rst_alldone", allDone8, 0);
        check_eq("mid_rst_done", Done8, 0);
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        bad8 = 0;
        repeat (5) begin
          @(negedge clk);
          if (allDone8 || dout8) bad8++;
        end
        check_eq("mid_quiet", bad8, 0);
        ship8 = 1'b1;
        recv(0, 192);
        ship8 = 1'b0;
        check_eq("f2_timeout", rx_to[0], 0);
        check_eq("f2_periods", rx_bad_per[0], 0);
        check_eq("f2_high_widths", rx_bad_hi[0], 0);
        check_eq("f2_frame_len", rx_total[0], 24000);
        check_eq("f2_pix_addr", rx_bad_addr[0], 0);
        for (int w = 0; w < 8; w++)
          check_eq($sformatf("f2_word%0d", w), rx_word[0][w], dimmed(24'h010101 * 24'(w)));
      end

      begin : thread_dut1
        logic [23:0] e;
        int guard1;
        e = dimmed(24'hA500FF);
        @(negedge clk);
        ship1 = 1'b1;
        @(negedge clk);
        ship1 = 1'b0;
        recv(1, 24);
        check_eq("s1_timeout", rx_to[1], 0);
        check_eq("s1_word", rx_word[1][0], e);
        check_eq("s1_periods", rx_bad_per[1], 0);
        check_eq("s1_high_widths", rx_bad_hi[1], 0);
        check_eq("s1_hi_bit0", rx_hi[1][0], e[23] ? 80 : 40);
        check_eq("s1_hi_bit1", rx_hi[1][1], e[22] ? 80 : 40);
        check_eq("s1_frame_len", rx_total[1], 3000);
        guard1 = 0;
        while (!allDone1 && guard1 < 300) begin
          @(negedge clk);
          guard1++;
        end
        check_eq("s1_alldone_seen", allDone1, 1);
        word1 = 24'hFF8004;
        @(negedge clk);
        @(negedge clk);
        check_eq("s1_idle_after", Done1, 0);
        ship1 = 1'b1;
        @(negedge clk);
        ship1 = 1'b0;
        recv(1, 24);
        check_eq("s2_timeout", rx_to[1], 0);
        check_eq("s2_word", rx_word[1][0], dimmed(24'hFF8004));
        check_eq("s2_periods", rx_bad_per[1], 0);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
